// File: rtl/rot_pkg.sv
// Shared helpers for the pipelined left rotator:
// width derivation and one power-of-two rotate step.
package rot_pkg;

    localparam int MAX_N = 6;
    localparam int MAX_W = 1 << MAX_N;

    function automatic int width_of(input int n);
        return 1 << n;
    endfunction

    // data must be zero above bit w-1; result is likewise zero-extended
    function automatic logic [MAX_W-1:0] rol_pow2(
        input logic [MAX_W-1:0] data,
        input int               w,
        input int               k,
        input logic             en
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] rot;
        int               s;
        s    = 1 << k;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        rot  = ((data << s) | (data >> (w - s))) & mask;
        return en ? rot : data;
    endfunction

endpackage

// File: rtl/rot_stage.sv
// One registered rotate stage: applies amt bit K as a
// left rotate by 2**K, with a valid/ready skid-free chain.
module rot_stage
    import rot_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    input  logic [width_of(N)-1:0] data_i,
    input  logic [N-1:0]           amt_i,
    input  logic                   ready_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [width_of(N)-1:0] data_o,
    output logic [N-1:0]           amt_o
);

    localparam int W = width_of(N);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic [N-1:0] amt_q;

    assign ready_o = !valid_q || ready_i;

    always_comb begin
        data_d = W'(rol_pow2(MAX_W'(data_i), W, K, amt_i[K]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            amt_q   <= amt_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;

endmodule

// File: rtl/pipe_left_rotator.sv
// Pipelined left barrel rotator between two valid/ready
// streams; N registered stages, one operand per cycle.
module pipe_left_rotator
    import rot_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width_of(N)-1:0] in_data,
    input  logic [N-1:0]           in_amt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [width_of(N)-1:0] out_data
);

    localparam int W = width_of(N);

    logic [N:0]   valid_w;
    logic [N:0]   ready_w;
    logic [W-1:0] data_w [N+1];
    logic [N-1:0] amt_w  [N+1];

    assign valid_w[0] = in_valid;
    assign data_w[0]  = in_data;
    assign amt_w[0]   = in_amt;
    assign ready_w[N] = out_ready;

    for (genvar k = 0; k < N; k++) begin : g_stage
        rot_stage #(
            .N(N),
            .K(k)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .valid_i (valid_w[k]),
            .data_i  (data_w[k]),
            .amt_i   (amt_w[k]),
            .ready_i (ready_w[k+1]),
            .ready_o (ready_w[k]),
            .valid_o (valid_w[k+1]),
            .data_o  (data_w[k+1]),
            .amt_o   (amt_w[k+1])
        );
    end

    // the last stage's remaining amount has no consumer
    logic [N-1:0] unused_amt;
    assign unused_amt = amt_w[N];

    assign in_ready  = reset_n && ready_w[0];
    assign out_valid = valid_w[N];
    assign out_data  = data_w[N];

endmodule

// File: tb/tb_pipe_left_rotator.sv
// Bench for pipe_left_rotator: directed cases plus random
// stream against a right-rotate reference scoreboard.
module tb_pipe_left_rotator;

    localparam int N = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [N-1:0] in_amt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    pipe_left_rotator #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           nout = 0;
    logic [W-1:0] exp_q[$];
    int           t_q[$];
    bit           ov_hist[$];
    bit           in_fired = 1'b0;
    bit           check_lat = 1'b0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] held = '0;

    function automatic logic [W-1:0] rotr(input int d, input int r);
        return W'(((d >> r) | (d << (W - r))) & 'hFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [W-1:0] e;
        int           t;
        @(negedge clk);
        in_fired = in_valid && in_ready;
        ov_hist.push_back(out_valid);
        if (stall_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held));
        end
        stall_prev = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out observed=%0h expected=none",
                       out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
                if (check_lat) chk("latency", 32'(cyc - t), 32'd3);
                nout++;
            end
        end
        if (in_fired) begin
            exp_q.push_back(rotr(int'(in_data), (W - int'(in_amt)) % W));
            t_q.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic [W-1:0] sd [4];
    logic [N-1:0] sa [4];
    int           n0;
    int           c0;
    int           acc;
    int           guard;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // basic rotate with latency check
        check_lat = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        in_amt    = 3'd1;
        n0 = nout;
        cycle();
        chk("basic_accept", 32'(in_fired), 32'd1);
        in_valid = 1'b0;
        drain(10);
        chk("basic_count", 32'(nout - n0), 32'd1);
        chk("basic_model", 32'(rotr(8'h81, 7)), 32'h03);

        // back-to-back stream
        sd = '{8'hB4, 8'hB4, 8'h12, 8'h5A};
        sa = '{3'd3, 3'd7, 3'd4, 3'd0};
        n0 = nout;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = sd[i];
            in_amt   = sa[i];
            cycle();
            chk("stream_in_ready", 32'(in_fired), 32'd1);
        end
        in_valid = 1'b0;
        drain(10);
        chk("stream_count", 32'(nout - n0), 32'd4);

        // backpressure: fill while stalled, then release
        check_lat = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        n0 = nout;
        for (int i = 0; i < 6; i++) begin
            in_valid = (acc < 4);
            in_data  = 8'h11 * W'(acc + 1);
            in_amt   = N'(acc + 2);
            cycle();
            if (in_fired) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        guard = 0;
        while ((acc < 4 || exp_q.size() > 0) && guard < 20) begin
            in_valid = (acc < 4);
            in_data  = 8'h11 * W'(acc + 1);
            in_amt   = N'(acc + 2);
            cycle();
            if (in_fired) acc++;
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_all_in", 32'(acc), 32'd4);
        chk("bp_out_count", 32'(nout - n0), 32'd4);

        // bubbles
        check_lat = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            in_data  = 8'hC3 ^ W'(i);
            in_amt   = N'(5 + i);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("bubble_v0", 32'(ov_hist[c0+3]), 32'd1);
        chk("bubble_v1", 32'(ov_hist[c0+4]), 32'd0);
        chk("bubble_v2", 32'(ov_hist[c0+5]), 32'd1);
        chk("bubble_empty", 32'(exp_q.size()), 32'd0);

        // reset with operands in flight
        check_lat = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h3C + W'(i);
            in_amt   = N'(i + 1);
            cycle();
        end
        in_valid = 1'b0;
        chk("mid_full", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        t_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_post_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) cycle();
        chk("mid_no_stale", 32'(out_valid), 32'd0);

        // random stream against right-rotate reference
        acc = 0;
        guard = 0;
        n0 = nout;
        while (acc < 1000 && guard < 5000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = W'($urandom);
            in_amt    = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            cycle();
            if (in_fired) acc++;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);
        chk("rand_in_count", 32'(acc), 32'd1000);
        chk("rand_out_count", 32'(nout - n0), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_left_rotator.md
Name: pipe_left_rotator

Overview:
- Pipelined, flow-controlled left barrel rotator. It is the companion of the team's combinational right rotator and is used where data rotated right must be restored, or where a registered rotate is needed.
- Operand width is 2**N bits. There are N log-stages, and stage k rotates left by 2**k when amt[k] is set.
- The block sits between two valid/ready streams. Each stage is registered, so throughput is one operand per cycle when no backpressure is applied.

Parameters:
- N, 3, log2 of data width. Data width is W = 2**N, shift-amount width is N, pipeline depth is N.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an operand.
- in_ready  out  1  block accepts the operand this cycle.
- in_data  in  W  operand to rotate.
- in_amt  in  N  left-rotate amount, 0..W-1.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream takes the result this cycle.
- out_data  out  W  rotated result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: all stage valid bits 0, all data and amount registers 0, out_valid 0, out_data 0. in_ready is forced 0 while reset_n is low.
- Reset mid-operation: all in-flight operands are discarded. No result is emitted for them after reset is released.
- Transfers: an input transfer occurs when in_valid && in_ready at a clk edge. An output transfer occurs when out_valid && out_ready.
- Stage registers: stage k (k = 0..N-1) holds valid_k, data_k and amt_k (the amt bits still to be applied).
- Stage 0 load: on an input transfer, data_0 = in_data rotated left by (in_amt[0] ? 1 : 0), and the amount is captured.
- Stage k load (k ≥ 1): data_k = data_{k-1} rotated left by (amt_{k-1}[k] ? 2**k : 0), and the amount is passed along.
- Output: out_data = data_{N-1}, out_valid = valid_{N-1}.
- Per-stage ready:
  - ready_{N-1} = !valid_{N-1} || out_ready.
  - ready_k = !valid_k || ready_{k+1}.
  - in_ready = ready_0 (when reset_n is high).
  - This is a combinational chain with no bubbles required.
- Stage advance: stage k loads from stage k-1 when ready_k is high. Its valid bit takes valid_{k-1}, so bubbles propagate as invalid entries.
- Hold under stall: a stalled stage holds data, amount and valid bit unchanged.
  - out_data must stay stable while out_valid && !out_ready.
- Latency: a result is visible N cycles after the input transfer when there is no backpressure.
- Throughput: one operand per cycle with continuous out_ready.
- Capacity: up to N operands in flight. When all stages are full and out_ready is 0, in_ready is 0.
- Simultaneous in and out transfer while full: allowed. Every stage shifts and the pipeline stays full.
- Arithmetic:
  - Rotation is modulo W. amt = 0 passes data unchanged.
  - Rotating left by amt equals rotating right by (W - amt) mod W.
  - No bits are lost and there is no sign handling.
- Ordering: results leave in input order, with a one-to-one correspondence between input and output transfers.

Decomposition:
- Package rot_pkg:
  - function rol_pow2(data, k, en), which returns data rotated left by 2**k when en is set, for a parametric width.
  - localparam helpers for computing W from N.
- Sub-module rot_stage(N, K): one registered stage holding valid/data/amt, with the ready_in/ready_out chain. The top level instantiates it N times in a generate loop.

Test Plan:
- Basic rotate: N=3, in_data=8'b1000_0001, amt=1, out_ready held 1 -> out_data=8'b0000_0011 exactly 3 cycles after the transfer.
- Stream: back-to-back inputs 8'hB4/amt 3, 8'hB4/amt 7, 8'h12/amt 4, 8'h5A/amt 0 with out_ready=1 -> outputs 8'hA5, 8'h5A, 8'h21, 8'h5A in order, on consecutive cycles, with in_ready held 1.
- Backpressure:
  - Fill with 4 operands while out_ready=0 -> in_ready falls to 0 after 3 accepted. out_data holds stable while out_valid=1.
  - Release out_ready -> all 4 results emitted in order, none lost or duplicated.
- Bubbles: inputs with in_valid toggling 1,0,1 -> out_valid pattern 1,0,1 delayed 3 cycles, with correct data.
- Reset mid-stream: assert reset_n=0 with 3 operands in flight -> out_valid=0 and out_data=0 immediately (asynchronously). After release, no stale result appears and in_ready=1.
- Inverse check: random 1000 operands/amounts, comparing each result against a right-rotate reference by (8 - amt) mod 8 -> zero mismatches.
